axis_lockin_cfg_sequencer: RTL
==============================

# axis_lockin_cfg_sequencer

Configuration sequencer for the RPSPMC lock-in datapath. It accepts frequency-change requests (DDS phase increment plus samples-per-period exponent N2) over an AXI-Stream handshake and pushes them to the DDS and lock-in. It then clears the lock-in moving-window correlator for one full reference period and discards a programmable number of settling periods. Only after that does it flag lock-in X/Y/A2 as valid. It sits between the PS control registers and the lock-in/DDS pair, and its valid flag gates downstream consumers such as the controller and scope.

## Interface
- LCK_BUFFER_LEN2, 10, log2 of lock-in correlator window memory depth
- DECII2_MAX, 16, maximum decimation exponent supported by the lock-in
- DPHASE_WIDTH, 44, DDS phase-increment width
- SETTLE_W, 8, width of settle-period count

Ports:
- a_clk  in  1  clock; all logic on rising edge
- a_reset  in  1  synchronous, active-high reset
- S_AXIS_CFG_tdata  in  64  [DPHASE_WIDTH-1:0] = dphase, [63:48] = requested N2
- S_AXIS_CFG_tvalid  in  1  request valid
- S_AXIS_CFG_tready  out  1  high in IDLE and RUN only
- settle_periods  in  SETTLE_W  full periods to discard after flush; sampled at handshake
- sample_strobe  in  1  one-cycle pulse per decimated lock-in sample
- M_AXIS_DPHASE_tdata  out  DPHASE_WIDTH  phase increment to DDS
- M_AXIS_DPHASE_tvalid  out  1  level, high once a config has been applied
- M_AXIS_DDS_N2_tdata  out  16  clamped N2 to lock-in
- M_AXIS_DDS_N2_tvalid  out  1  same as DPHASE_tvalid
- lck_clear  out  1  high during FLUSH
- lck_valid  out  1  high in RUN
- cfg_err  out  1  sticky; set when requested N2 was clamped; cleared by reset or by the next unclamped handshake
- state_mon  out  3  current state encoding for debug

## Operation
- States: IDLE=0, APPLY=1, FLUSH=2, SETTLE=3, RUN=4.
- IDLE: tready=1. On tvalid&tready, latch the config and settle_periods, then go to APPLY.
- N2 clamp: n2c = min(N2, LCK_BUFFER_LEN2+DECII2_MAX). Set cfg_err when N2 > that limit.
- eff_n2 = min(n2c, LCK_BUFFER_LEN2). Period = 2^eff_n2 sample strobes.
- APPLY: lasts one cycle. Outputs dphase/n2c are registered and both tvalids are set. Go to FLUSH.
- FLUSH: lck_clear=1. Count sample strobes up to the period.
  - On the strobe that completes the period, go to SETTLE.
  - If settle_periods==0, go directly to RUN instead.
- SETTLE: count periods × strobes. After the last strobe of period settle_periods, go to RUN.
- RUN: lck_valid=1, tready=1.
  - A handshake goes to APPLY. lck_valid drops on the edge following the handshake.
  - Output tdata updates in APPLY, not in RUN.
- Counters:
  - strobe counter is LCK_BUFFER_LEN2+1 bits.
  - period counter is SETTLE_W bits.
  - Both zero on every state entry.
- A sample_strobe in the same cycle as a state entry counts for the new state.
- A request with identical config in RUN is still honoured: full flush and settle.

## Timing
- Reset values: state IDLE, tready=0 during reset cycle then 1, all tdata=0, tvalids=0, lck_clear=0, lck_valid=0, cfg_err=0, state_mon=0.
- Handshake at edge T: APPLY for cycle T+1. M_AXIS_* tdata/tvalid valid from T+1. lck_clear=1 from T+2.
- Latency from handshake to lck_valid, with strobes every cycle: 2 + 2^eff_n2·(1+settle_periods) cycles.
- Reset asserted mid-operation: IDLE next edge. All outputs return to reset values, including DDS tvalids.
- tvalid held high in FLUSH/SETTLE is ignored (tready=0). The request is taken once RUN is reached.

## Structure
- Package lck_seq_pkg holds:
  - state enum
  - CFG field offsets: DPHASE_LSB=0, N2_LSB=48, N2_W=16
  - N2_MAX function (LCK_BUFFER_LEN2+DECII2_MAX)
- Sub-module lck_period_counter: counts strobes to 2^eff_n2 and emits period_done. It is instantiated once and reused by FLUSH and SETTLE.

## Test plan
- N2=12, settle=2, strobe every cycle.
  - Response: n2c=12, eff_n2=10.
  - lck_clear high exactly 1024 cycles.
  - lck_valid rises at handshake+2+3072.
- N2=30:
  - Response: M_AXIS_DDS_N2_tdata=26, cfg_err=1.
  - A subsequent N2=8 clears cfg_err; period=256.
- settle_periods=0, N2=3:
  - Response: FLUSH 8 strobes, then RUN directly.
  - SETTLE never visible on state_mon.
- New request in RUN:
  - Response: lck_valid=0 on the next edge.
  - Outputs show the new dphase the cycle after the handshake.
  - A request offered during FLUSH stays pending until RUN.
- Reset asserted mid-SETTLE:
  - Response: all outputs zero next edge, tready=1 after reset is released.
- Strobe every 4th cycle, N2=2, settle=1:
  - Response: lck_valid after 8 strobes; counters ignore cycles without a strobe.

Source files
------------

// File: rtl/axis_lockin_cfg_sequencer_pkg.sv
// Shared types and constants for the lock-in configuration sequencer.
// Holds the state encoding, the config word field offsets and the N2 limit helper.
package lck_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  localparam int DPHASE_LSB = 0;
  localparam int N2_LSB     = 48;
  localparam int N2_W       = 16;

  // Largest N2 the lock-in can honour: window depth exponent plus maximum decimation.
  function automatic int N2_MAX(input int lckBufferLen2, input int decii2Max);
    return lckBufferLen2 + decii2Max;
  endfunction

endpackage

// File: rtl/axis_lockin_cfg_sequencer_if.sv
// AXI-Stream request channel carrying {N2, dphase} configuration words.
interface axis_lockin_cfg_sequencer_if;
  import lck_seq_pkg::*;

  logic [N2_LSB+N2_W-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_lockin_cfg_sequencer_period_counter.sv
// Counts sample strobes up to 2^eff_n2 and flags the strobe that closes a period.
// The count wraps on period completion so consecutive settle periods reuse it.
module lck_period_counter #(
  parameter int CNT_W = 11,
  parameter int EFF_W = 4
) (
  input  logic             a_clk,
  input  logic             a_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_strobe,
  input  logic [EFF_W-1:0] i_effN2,
  output logic             o_periodDone
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last       = (CNT_W'(1) << i_effN2) - CNT_W'(1);
  assign o_periodDone = i_enable && i_strobe && (r_count == w_last);

  always_ff @(posedge a_clk) begin
    if (a_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && i_strobe) begin
      r_count <= o_periodDone ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axis_lockin_cfg_sequencer.sv
// Accepts DDS/lock-in frequency changes, flushes the correlator for one period,
// discards settle periods, then flags the lock-in outputs as valid.
module axis_lockin_cfg_sequencer
  import lck_seq_pkg::*;
#(
  parameter int LCK_BUFFER_LEN2 = 10,
  parameter int DECII2_MAX      = 16,
  parameter int DPHASE_WIDTH    = 44,
  parameter int SETTLE_W        = 8
) (
  input  logic                        a_clk,
  input  logic                        a_reset,
  axis_lockin_cfg_sequencer_if.slave  S_AXIS_CFG,
  input  logic [SETTLE_W-1:0]         settle_periods,
  input  logic                        sample_strobe,
  output logic [DPHASE_WIDTH-1:0]     M_AXIS_DPHASE_tdata,
  output logic                        M_AXIS_DPHASE_tvalid,
  output logic [N2_W-1:0]             M_AXIS_DDS_N2_tdata,
  output logic                        M_AXIS_DDS_N2_tvalid,
  output logic                        lck_clear,
  output logic                        lck_valid,
  output logic                        cfg_err,
  output logic [2:0]                  state_mon
);

  localparam int CNT_W = LCK_BUFFER_LEN2 + 1;
  localparam int EFF_W = $clog2(LCK_BUFFER_LEN2 + 1);
  localparam logic [N2_W-1:0]   N2_LIMIT  = N2_W'(N2_MAX(LCK_BUFFER_LEN2, DECII2_MAX));
  localparam logic [N2_W-1:0]   EFF_LIMIT = N2_W'(LCK_BUFFER_LEN2);
  localparam logic [SETTLE_W:0] ONE_X     = 1;

  state_t                  r_state, w_nextState;
  logic                    w_ready, w_handshake, w_periodDone, w_clamp, w_lastPeriod;
  logic [N2_W-1:0]         w_n2Req, w_n2c, r_n2c;
  logic [EFF_W-1:0]        w_effN2, r_effN2;
  logic [SETTLE_W-1:0]     r_settle, r_period;
  logic [DPHASE_WIDTH-1:0] r_dphase;
  logic                    r_outValid, r_cfgErr;

  assign w_n2Req     = S_AXIS_CFG.tdata[N2_LSB +: N2_W];
  assign w_clamp     = w_n2Req > N2_LIMIT;
  assign w_n2c       = w_clamp ? N2_LIMIT : w_n2Req;
  assign w_effN2     = (w_n2c > EFF_LIMIT) ? EFF_W'(LCK_BUFFER_LEN2) : w_n2c[EFF_W-1:0];
  assign w_ready     = !a_reset && (r_state == ST_IDLE || r_state == ST_RUN);
  assign w_handshake = S_AXIS_CFG.tvalid && w_ready;
  assign w_lastPeriod = ({1'b0, r_period} + ONE_X) == {1'b0, r_settle};

  assign S_AXIS_CFG.tready    = w_ready;
  assign M_AXIS_DPHASE_tdata  = r_dphase;
  assign M_AXIS_DPHASE_tvalid = r_outValid;
  assign M_AXIS_DDS_N2_tdata  = r_n2c;
  assign M_AXIS_DDS_N2_tvalid = r_outValid;
  assign cfg_err              = r_cfgErr;
  assign state_mon            = r_state;

  if (DPHASE_WIDTH < N2_LSB) begin : g_gap
    logic w_unusedGap;
    assign w_unusedGap = ^S_AXIS_CFG.tdata[N2_LSB-1:DPHASE_WIDTH];
  end

  always_ff @(posedge a_clk) begin
    if (a_reset) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    lck_clear   = 1'b0;
    lck_valid   = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_handshake) w_nextState = ST_APPLY;
      ST_APPLY:  w_nextState = ST_FLUSH;
      ST_FLUSH: begin
        lck_clear = 1'b1;
        if (w_periodDone) w_nextState = (r_settle == '0) ? ST_RUN : ST_SETTLE;
      end
      ST_SETTLE: if (w_periodDone && w_lastPeriod) w_nextState = ST_RUN;
      ST_RUN: begin
        lck_valid = 1'b1;
        if (w_handshake) w_nextState = ST_APPLY;
      end
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Config is captured on the handshake edge so the DDS sees it during APPLY.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      r_dphase   <= '0;
      r_n2c      <= '0;
      r_effN2    <= '0;
      r_settle   <= '0;
      r_outValid <= 1'b0;
      r_cfgErr   <= 1'b0;
    end else if (w_handshake) begin
      r_dphase   <= S_AXIS_CFG.tdata[DPHASE_LSB +: DPHASE_WIDTH];
      r_n2c      <= w_n2c;
      r_effN2    <= w_effN2;
      r_settle   <= settle_periods;
      r_outValid <= 1'b1;
      r_cfgErr   <= w_clamp;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_reset || (w_nextState != r_state)) r_period <= '0;
    else if (r_state == ST_SETTLE && w_periodDone) r_period <= r_period + SETTLE_W'(1);
  end

  lck_period_counter #(
    .CNT_W (CNT_W),
    .EFF_W (EFF_W)
  ) u_periodCounter (
    .a_clk        (a_clk),
    .a_reset      (a_reset),
    .i_clear      (w_nextState != r_state),
    .i_enable     (r_state == ST_FLUSH || r_state == ST_SETTLE),
    .i_strobe     (sample_strobe),
    .i_effN2      (r_effN2),
    .o_periodDone (w_periodDone)
  );

endmodule
